// File: rtl/control_unit.sv
// control_unit
// Decodes the datapath opcode into its control strobes and supervises execution.
// The supervision covers a RUN/HALT state machine, a sticky illegal-opcode flag
// and a saturating retired-instruction counter.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high reset
//   Opcode   - instruction[15:10] from the datapath
//   zero     - ALU zero flag from the datapath
//   s_inc    - PC source: 1 = PC+1, 0 = jump_addr
//   s_inm    - 1 = immediate operand / read port 1 from WA3
//   we       - register-file write enable
//   wez      - zero-flag write enable
//   ALUOp    - ALU operation
//   halted   - 1 while in HALT
//   illegal  - sticky illegal-opcode flag
//   retired  - saturating count of instructions retired in RUN
module control_unit #(
  parameter int CNT_W           = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, next_state;

  logic       dec_s_inc;
  logic       dec_s_inm;
  logic       dec_we;
  logic       dec_wez;
  logic [2:0] dec_alu;
  logic       op_illegal;
  logic       op_halt;

  // Pure instruction decode, independent of state and reset. Illegal codes
  // fall through with the NOP defaults so they execute harmlessly.
  always_comb begin
    dec_s_inc  = 1'b1;
    dec_s_inm  = 1'b0;
    dec_we     = 1'b0;
    dec_wez    = 1'b0;
    dec_alu    = 3'b000;
    op_illegal = 1'b0;
    op_halt    = 1'b0;
    if (!Opcode[5]) begin
      // Reg-reg ALU op; Opcode[1:0] belong to RA1 and are not decoded.
      dec_we  = 1'b1;
      dec_wez = 1'b1;
      dec_alu = Opcode[4:2];
    end else if (!Opcode[4]) begin
      case (Opcode[3:2])
        2'b00:   dec_alu = 3'b000;
        2'b01:   dec_alu = 3'b010;
        2'b10:   dec_alu = 3'b011;
        default: op_illegal = 1'b1;
      endcase
      if (Opcode[3:2] != 2'b11) begin
        dec_s_inm = 1'b1;
        dec_we    = 1'b1;
        dec_wez   = 1'b1;
      end
    end else begin
      case (Opcode[3:0])
        4'b0000: dec_s_inc = 1'b0;
        4'b0001: dec_s_inc = ~zero;
        4'b0010: dec_s_inc = zero;
        4'b0011: begin
          dec_s_inc = 1'b0;
          op_halt   = 1'b1;
        end
        4'b1111: dec_s_inc = 1'b1;
        default: op_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // HALT is only left through reset.
  always_comb begin
    next_state = state;
    if (state == RUN && (op_halt || (TRAP_ON_ILLEGAL && op_illegal)))
      next_state = HALT;
  end

  // Reset overrides combinationally so an in-flight write is aborted at once.
  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we     = 1'b0;
    wez    = 1'b0;
    ALUOp  = 3'b000;
    halted = (state == HALT);
    if (!reset) begin
      if (state == HALT) begin
        s_inc = 1'b0;
      end else begin
        s_inc = dec_s_inc;
        s_inm = dec_s_inm;
        we    = dec_we;
        wez   = dec_wez;
        ALUOp = dec_alu;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal <= 1'b0;
    else if (state == RUN && op_illegal)
      illegal <= 1'b1;
  end

  // Every RUN cycle retires one instruction, including HALT and illegal ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (state == RUN && retired != {CNT_W{1'b1}})
      retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Drives three control_unit instances (default, 4-bit counter, trap-on-illegal)
// from shared inputs and checks them against a behavioural model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'b000000;
  logic       zero = 1'b0;

  logic       s_inc0, s_inm0, we0, wez0, halted0, illegal0;
  logic [2:0] alu0;
  logic [15:0] ret0;
  logic       s_inc1, s_inm1, we1, wez1, halted1, illegal1;
  logic [2:0] alu1;
  logic [3:0] ret1;
  logic       s_inc2, s_inm2, we2, wez2, halted2, illegal2;
  logic [2:0] alu2;
  logic [15:0] ret2;

  logic [6:0]  ctrl_v [3];
  logic        halted_v [3];
  logic        illegal_v [3];
  logic [15:0] ret_v [3];

  int total = 0;
  int bad = 0;

  int m_max [3] = '{65535, 15, 65535};
  bit m_trap [3] = '{1'b0, 1'b0, 1'b1};
  bit m_halt [3];
  bit m_ill [3];
  int m_ret [3];

  always #5 clk = ~clk;

  control_unit #(.CNT_W(16), .TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .s_inc(s_inc0), .s_inm(s_inm0), .we(we0), .wez(wez0), .ALUOp(alu0),
    .halted(halted0), .illegal(illegal0), .retired(ret0)
  );

  control_unit #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .s_inc(s_inc1), .s_inm(s_inm1), .we(we1), .wez(wez1), .ALUOp(alu1),
    .halted(halted1), .illegal(illegal1), .retired(ret1)
  );

  control_unit #(.CNT_W(16), .TRAP_ON_ILLEGAL(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .s_inc(s_inc2), .s_inm(s_inm2), .we(we2), .wez(wez2), .ALUOp(alu2),
    .halted(halted2), .illegal(illegal2), .retired(ret2)
  );

  assign ctrl_v[0]    = {s_inc0, s_inm0, we0, wez0, alu0};
  assign ctrl_v[1]    = {s_inc1, s_inm1, we1, wez1, alu1};
  assign ctrl_v[2]    = {s_inc2, s_inm2, we2, wez2, alu2};
  assign halted_v[0]  = halted0;
  assign halted_v[1]  = halted1;
  assign halted_v[2]  = halted2;
  assign illegal_v[0] = illegal0;
  assign illegal_v[1] = illegal1;
  assign illegal_v[2] = illegal2;
  assign ret_v[0]     = ret0;
  assign ret_v[1]     = {12'b0, ret1};
  assign ret_v[2]     = ret2;

  // Instruction-set view of the opcode space.
  function automatic bit is_illegal(input logic [5:0] op);
    int hi = op[5:2];
    int lo = op[3:0];
    if (hi == 11) return 1'b1;
    if (op[5:4] == 2'b11 && !(lo <= 3 || lo == 15)) return 1'b1;
    return 1'b0;
  endfunction

  // Expected {s_inc, s_inm, we, wez, ALUOp}.
  function automatic logic [6:0] exp_ctrl(input logic [5:0] op, input logic z,
                                          input bit hlt, input bit rst);
    logic [6:0] nop_v = 7'b1000000;
    if (rst) return nop_v;
    if (hlt) return 7'b0000000;
    if (is_illegal(op)) return nop_v;
    case (op[5:4])
      2'b00, 2'b01: return {4'b1011, op[4:2]};
      2'b10: begin
        if (op[3:2] == 2'b00) return 7'b1111000;
        if (op[3:2] == 2'b01) return 7'b1111010;
        return 7'b1111011;
      end
      default: begin
        if (op == 6'b110000) return 7'b0000000;
        if (op == 6'b110001) return {~z, 6'b000000};
        if (op == 6'b110010) return {z, 6'b000000};
        if (op == 6'b110011) return 7'b0000000;
        return nop_v;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_halt[k] = 1'b0;
      m_ill[k]  = 1'b0;
      m_ret[k]  = 0;
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z);
    @(negedge clk);
    Opcode = op;
    zero   = z;
    #1;
  endtask

  // Advances one edge and applies the architectural effect to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!m_halt[k]) begin
        if (m_ret[k] < m_max[k]) m_ret[k] = m_ret[k] + 1;
        if (is_illegal(Opcode)) begin
          m_ill[k] = 1'b1;
          if (m_trap[k]) m_halt[k] = 1'b1;
        end
        if (Opcode == 6'b110011) m_halt[k] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(6'b000100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ctrl_v[k] !== 7'b1000000 || halted_v[k] !== 1'b0 ||
          illegal_v[k] !== 1'b0 || ret_v[k] !== 16'd0) begin
        bad++;
        $display("[TB] FAIL reset_state dut%0d got ctrl=%b h=%b i=%b r=%0d want ctrl=1000000 h=0 i=0 r=0",
                 k, ctrl_v[k], halted_v[k], illegal_v[k], ret_v[k]);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (ctrl_v[0] !== 7'b1011001) begin
      bad++;
      $display("[TB] FAIL alu_decode got=%b want=1011001", ctrl_v[0]);
    end
    tick();
    total++;
    if (ret_v[0] !== 16'd1) begin
      bad++;
      $display("[TB] FAIL first_retire got=%0d want=1", ret_v[0]);
    end
  endtask

  task automatic test_alu_and_illegal();
    do_reset();
    drive(6'b100100, 1'b0);
    total++;
    if (ctrl_v[0] !== 7'b1111010) begin
      bad++;
      $display("[TB] FAIL addi_decode got=%b want=1111010", ctrl_v[0]);
    end
    tick();
    drive(6'b101100, 1'b0);
    total++;
    if (ctrl_v[0] !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL illegal_nop got=%b want=1000000", ctrl_v[0]);
    end
    tick();
    total++;
    if (illegal_v[0] !== 1'b1 || halted_v[0] !== 1'b0 || ret_v[0] !== 16'd2) begin
      bad++;
      $display("[TB] FAIL illegal_flag got i=%b h=%b r=%0d want i=1 h=0 r=2",
               illegal_v[0], halted_v[0], ret_v[0]);
    end
    drive(6'b101000, 1'b1);
    total++;
    if (ctrl_v[0] !== 7'b1111011) begin
      bad++;
      $display("[TB] FAIL subi_decode got=%b want=1111011", ctrl_v[0]);
    end
    tick();
    total++;
    if (illegal_v[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL illegal_sticky got=%b want=1", illegal_v[0]);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{6'b110001, 6'b110001, 6'b110010, 6'b110010};
    logic       zs [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] want [4] = '{7'b0000000, 7'b1000000, 7'b1000000, 7'b0000000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], zs[i]);
      total++;
      if (ctrl_v[0] !== want[i]) begin
        bad++;
        $display("[TB] FAIL branch%0d op=%b z=%b got=%b want=%b",
                 i, ops[i], zs[i], ctrl_v[0], want[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(6'b000000, 1'b0);
    tick();
    drive(6'b110011, 1'b0);
    total++;
    if (s_inc0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL halt_sinc got=%b want=0", s_inc0);
    end
    tick();
    total++;
    if (halted_v[0] !== 1'b1 || ret_v[0] !== 16'd2) begin
      bad++;
      $display("[TB] FAIL halt_enter got h=%b r=%0d want h=1 r=2", halted_v[0], ret_v[0]);
    end
    for (int i = 0; i < 5; i++) begin
      drive(6'b000000, 1'($urandom_range(0, 1)));
      total++;
      if (ctrl_v[0] !== 7'b0000000) begin
        bad++;
        $display("[TB] FAIL halt_outputs%0d got=%b want=0000000", i, ctrl_v[0]);
      end
      tick();
      total++;
      if (ret_v[0] !== 16'd2 || halted_v[0] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL halt_frozen%0d got h=%b r=%0d want h=1 r=2", i, halted_v[0], ret_v[0]);
      end
    end
    reset = 1'b1;
    #1;
    total++;
    if (halted_v[0] !== 1'b0 || ret_v[0] !== 16'd0 || ctrl_v[0] !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL async_reset got h=%b r=%0d ctrl=%b want h=0 r=0 ctrl=1000000",
               halted_v[0], ret_v[0], ctrl_v[0]);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(6'b111111, 1'b0);
      tick();
      want = (i + 1 > 15) ? 15 : i + 1;
      total++;
      if (ret_v[1] !== 16'(want)) begin
        bad++;
        $display("[TB] FAIL saturate%0d got=%0d want=%0d", i, ret_v[1], want);
      end
    end
  endtask

  task automatic test_trap();
    do_reset();
    drive(6'b110100, 1'b0);
    tick();
    total++;
    if (illegal_v[2] !== 1'b1 || halted_v[2] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL trap_same_edge got i=%b h=%b want i=1 h=1", illegal_v[2], halted_v[2]);
    end
    total++;
    if (halted_v[0] !== 1'b0 || illegal_v[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL no_trap got i=%b h=%b want i=1 h=0", illegal_v[0], halted_v[0]);
    end
    do_reset();
    drive(6'b010000, 1'b0);
    total++;
    if (we2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL write_before_reset got=%b want=1", we2);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (we2 !== 1'b0 || wez2 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midcycle_reset got we=%b wez=%b want 0 0", we2, wez2);
    end
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic       z;
    logic [6:0] want;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ((m_halt[0] || m_halt[2]) && $urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
          total++;
          if (ctrl_v[k] !== 7'b1000000 || halted_v[k] !== 1'b0 || ret_v[k] !== 16'd0) begin
            bad++;
            $display("[TB] FAIL rand_reset dut%0d got ctrl=%b h=%b r=%0d",
                     k, ctrl_v[k], halted_v[k], ret_v[k]);
          end
        end
        reset = 1'b0;
      end
      op = 6'($urandom);
      z  = 1'($urandom);
      drive(op, z);
      for (int k = 0; k < 3; k++) begin
        want = exp_ctrl(op, z, m_halt[k], 1'b0);
        total++;
        if (ctrl_v[k] !== want) begin
          bad++;
          $display("[TB] FAIL rand_ctrl dut%0d op=%b z=%b got=%b want=%b",
                   k, op, z, ctrl_v[k], want);
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (halted_v[k] !== m_halt[k] || illegal_v[k] !== m_ill[k] ||
            ret_v[k] !== 16'(m_ret[k])) begin
          bad++;
          $display("[TB] FAIL rand_state dut%0d got h=%b i=%b r=%0d want h=%b i=%b r=%0d",
                   k, halted_v[k], illegal_v[k], ret_v[k], m_halt[k], m_ill[k], m_ret[k]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_alu_and_illegal();
    test_branch();
    test_halt();
    test_saturate();
    test_trap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
